// File: rtl/adder_result_checker.sv
// adder_result_checker
//   Self-checking sink for adder regressions. Takes operand/result tuples from
//   two adder implementations and checks both against a golden a+b computed at
//   WIDTH+1 bits. It counts the checks and the mismatches, and it captures the
//   first failing tuple.
//
//   Pipeline: accept (edge N) -> S1 register -> S2 compare register -> the
//   counters, flags and FSM update at edge N+2. One tuple per cycle is accepted.
//
//   Optional feature macro: CHK_STOP_ON_ERR_EN
//     defined   : once FAIL is reached, in_ready stays 0 until rst/clear.
//                 Tuples already in the pipeline still complete.
//     undefined : checking continues after a mismatch.
//
// Ports
//   clk, rst               clock, synchronous active-high reset
//   in_valid / in_ready    tuple handshake (in_ready is 0 while clear is high)
//   a, b                   operands
//   s0/co0, s1/co1         sum and carry from implementation 0 and 1
//   clear                  synchronous soft clear (same effect as rst)
//   check_cnt, err_cnt     saturating counts of checked / mismatching tuples
//   err                    sticky fail (state == FAIL)
//   err_flags              sticky [0] impl0 wrong, [1] impl1 wrong, [2] impl0!=impl1
//   first_a/b, first_s0/s1 first failing tuple; s fields are {co,s}
module adder_result_checker #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] s0,
  input  logic             co0,
  input  logic [WIDTH-1:0] s1,
  input  logic             co1,
  input  logic             clear,
  output logic [CNT_W-1:0] check_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic             err,
  output logic [2:0]       err_flags,
  output logic [WIDTH-1:0] first_a,
  output logic [WIDTH-1:0] first_b,
  output logic [WIDTH:0]   first_s0,
  output logic [WIDTH:0]   first_s1
);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, FAIL = 2'd2} state_t;

  state_t           r_state;

  // S1: the raw tuple
  logic             r_s1_vld;
  logic [WIDTH-1:0] r_s1_a, r_s1_b;
  logic [WIDTH:0]   r_s1_r0, r_s1_r1;

  // S2: the tuple plus its per-tuple mismatch flags
  logic             r_s2_vld;
  logic [WIDTH-1:0] r_s2_a, r_s2_b;
  logic [WIDTH:0]   r_s2_r0, r_s2_r1;
  logic [2:0]       r_s2_flags;

  logic [CNT_W-1:0] r_chk, r_errc;
  logic [2:0]       r_flags;
  logic [WIDTH-1:0] r_fa, r_fb;
  logic [WIDTH:0]   r_fs0, r_fs1;

  logic             w_acc;
  logic [WIDTH:0]   w_gold;
  logic [2:0]       w_flags;
  logic             w_bad;

`ifdef CHK_STOP_ON_ERR_EN
  assign in_ready = !clear && (r_state != FAIL);
`else
  assign in_ready = !clear;
`endif

  assign w_acc  = in_valid && in_ready;
  // Golden sum is computed one bit wider, so the carry out is never lost.
  assign w_gold = {1'b0, r_s1_a} + {1'b0, r_s1_b};
  // Bit 2 is computed on its own, separately from bits 0 and 1.
  assign w_flags = {r_s1_r0 != r_s1_r1, r_s1_r1 != w_gold, r_s1_r0 != w_gold};
  assign w_bad   = r_s2_flags[0] | r_s2_flags[1];

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      r_s1_vld <= 1'b0;
      r_s2_vld <= 1'b0;
    end else begin
      r_s1_vld <= w_acc;
      r_s2_vld <= r_s1_vld;
    end
    if (w_acc) begin
      r_s1_a  <= a;
      r_s1_b  <= b;
      r_s1_r0 <= {co0, s0};
      r_s1_r1 <= {co1, s1};
    end
    if (r_s1_vld) begin
      r_s2_a     <= r_s1_a;
      r_s2_b     <= r_s1_b;
      r_s2_r0    <= r_s1_r0;
      r_s2_r1    <= r_s1_r1;
      r_s2_flags <= w_flags;
    end
  end

  // Counters, sticky flags, FSM and first-failure capture
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      r_state <= IDLE;
      r_chk   <= '0;
      r_errc  <= '0;
      r_flags <= '0;
      r_fa    <= '0;
      r_fb    <= '0;
      r_fs0   <= '0;
      r_fs1   <= '0;
    end else if (r_s2_vld) begin
      if (r_chk != '1)           r_chk  <= r_chk + CNT_W'(1);
      if (w_bad && r_errc != '1) r_errc <= r_errc + CNT_W'(1);
      r_flags <= r_flags | r_s2_flags;
      case (r_state)
        IDLE, RUN: begin
          if (w_bad) begin
            r_state <= FAIL;
            r_fa    <= r_s2_a;
            r_fb    <= r_s2_b;
            r_fs0   <= r_s2_r0;
            r_fs1   <= r_s2_r1;
          end else begin
            r_state <= RUN;
          end
        end
        default: r_state <= FAIL;
      endcase
    end
  end

  assign check_cnt = r_chk;
  assign err_cnt   = r_errc;
  assign err       = (r_state == FAIL);
  assign err_flags = r_flags;
  assign first_a   = r_fa;
  assign first_b   = r_fb;
  assign first_s0  = r_fs0;
  assign first_s1  = r_fs1;

endmodule

// File: tb/tb_adder_result_checker.sv
// Scoreboard bench for adder_result_checker. The stimulus side runs a small
// model and pushes the expected post-update state for each tuple that will be
// counted. The monitor tracks accepts two edges deep. On each counting edge it
// pops one entry and compares it. A second instance with CNT_W=2 shares the
// inputs, so it exercises counter saturation.
module tb_adder_result_checker;

  logic       clk = 1'b0;
  logic       rst, in_valid, clear;
  logic [3:0] a, b, s0, s1;
  logic       co0, co1;

  logic        in_ready, err, in_ready2, err2;
  logic [15:0] check_cnt, err_cnt;
  logic [1:0]  check_cnt2, err_cnt2;
  logic [2:0]  err_flags, err_flags2;
  logic [3:0]  first_a, first_b, first_a2, first_b2;
  logic [4:0]  first_s0, first_s1, first_s02, first_s12;

  always #5 clk = ~clk;

  adder_result_checker #(.WIDTH(4), .CNT_W(16)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .s0(s0), .co0(co0), .s1(s1), .co1(co1), .clear(clear),
    .check_cnt(check_cnt), .err_cnt(err_cnt), .err(err), .err_flags(err_flags),
    .first_a(first_a), .first_b(first_b), .first_s0(first_s0), .first_s1(first_s1));

  adder_result_checker #(.WIDTH(4), .CNT_W(2)) u_sat (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2),
    .a(a), .b(b), .s0(s0), .co0(co0), .s1(s1), .co1(co1), .clear(clear),
    .check_cnt(check_cnt2), .err_cnt(err_cnt2), .err(err2), .err_flags(err_flags2),
    .first_a(first_a2), .first_b(first_b2), .first_s0(first_s02), .first_s1(first_s12));

  typedef struct {
    int         chk, errc, chk2, errc2;
    logic       fail;
    logic [2:0] flags;
    logic [3:0] fa, fb;
    logic [4:0] fs0, fs1;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  // model state
  int         m_chk, m_errc, m_chk2, m_errc2;
  logic       m_fail;
  logic [2:0] m_flags;
  logic [3:0] m_fa, m_fb;
  logic [4:0] m_fs0, m_fs1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_chk = 0; m_errc = 0; m_chk2 = 0; m_errc2 = 0;
    m_fail = 1'b0; m_flags = '0;
    m_fa = '0; m_fb = '0; m_fs0 = '0; m_fs1 = '0;
  endtask

  function automatic logic exp_ready();
`ifdef CHK_STOP_ON_ERR_EN
    return !m_fail;
`else
    return 1'b1;
`endif
  endfunction

  task automatic model_tuple(input logic [3:0] ta, tb, ts0, input logic tco0,
                             input logic [3:0] ts1, input logic tco1);
    logic [4:0] g, r0, r1;
    logic       m0, m1;
    exp_t       e;
    g  = {1'b0, ta} + {1'b0, tb};
    r0 = {tco0, ts0};
    r1 = {tco1, ts1};
    m0 = (r0 != g);
    m1 = (r1 != g);
    if (m_chk < 65535) m_chk++;
    if (m_chk2 < 3)    m_chk2++;
    if (m0 || m1) begin
      if (m_errc < 65535) m_errc++;
      if (m_errc2 < 3)    m_errc2++;
      if (!m_fail) begin
        m_fail = 1'b1;
        m_fa = ta; m_fb = tb; m_fs0 = r0; m_fs1 = r1;
      end
    end
    m_flags = m_flags | {r0 != r1, m1, m0};
    e.chk = m_chk; e.errc = m_errc; e.chk2 = m_chk2; e.errc2 = m_errc2;
    e.fail = m_fail; e.flags = m_flags;
    e.fa = m_fa; e.fb = m_fb; e.fs0 = m_fs0; e.fs1 = m_fs1;
    exp_q.push_back(e);
  endtask

  // Drive one tuple for one cycle. When push=0 the tuple is expected to be
  // dropped by a later clear or rst, so the model ignores it.
  task automatic send(input logic [3:0] ta, tb, ts0, input logic tco0,
                      input logic [3:0] ts1, input logic tco1, input bit push = 1'b1);
    logic r;
    @(negedge clk);
    in_valid = 1'b1; a = ta; b = tb; s0 = ts0; co0 = tco0; s1 = ts1; co1 = tco1;
    #1;
    r = exp_ready();
    check("in_ready", in_ready, r);
    check("in_ready_sat", in_ready2, r);
    if (r && push) model_tuple(ta, tb, ts0, tco0, ts1, tco1);
  endtask

  task automatic drain();
    @(negedge clk) in_valid = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic check_idle_state(input string tag);
    check({tag, "_check_cnt"}, check_cnt, 0);
    check({tag, "_err_cnt"}, err_cnt, 0);
    check({tag, "_err"}, err, 0);
    check({tag, "_err_flags"}, err_flags, 0);
    check({tag, "_first_a"}, first_a, 0);
    check({tag, "_first_s1"}, first_s1, 0);
  endtask

  task automatic do_clear();
    @(negedge clk);
    clear = 1'b1; in_valid = 1'b1; a = 4'd1; b = 4'd1; s0 = 4'd2; s1 = 4'd2;
    co0 = 1'b0; co1 = 1'b0;
    #1 check("in_ready_in_clear", in_ready, 0);
    model_reset();
    @(negedge clk);
    clear = 1'b0; in_valid = 1'b0;
    #1 check("in_ready_after_clear", in_ready, 1);
    check_idle_state("clear");
  endtask

  // Monitor: track accepts through two pipeline slots. A tuple from slot 1
  // at a non-clear, non-reset edge is the one counted on that edge.
  initial begin
    logic p0, p1, fire;
    exp_t e;
    p0 = 1'b0; p1 = 1'b0;
    forever begin
      @(posedge clk);
      fire = p1 && !rst && !clear;
      if (rst || clear) begin
        p0 = 1'b0; p1 = 1'b0;
      end else begin
        p1 = p0;
        p0 = in_valid && in_ready;
      end
      if (fire) begin
        #1;
        if (exp_q.size() == 0) begin
          errors++; checks++;
          $display("FAIL scoreboard_underflow: got update expected none at %0t", $time);
        end else begin
          e = exp_q.pop_front();
          check("sb_check_cnt", check_cnt, e.chk);
          check("sb_err_cnt", err_cnt, e.errc);
          check("sb_err", err, e.fail);
          check("sb_err_flags", err_flags, e.flags);
          check("sb_first_a", first_a, e.fa);
          check("sb_first_b", first_b, e.fb);
          check("sb_first_s0", first_s0, e.fs0);
          check("sb_first_s1", first_s1, e.fs1);
          check("sb_sat_check_cnt", check_cnt2, e.chk2);
          check("sb_sat_err_cnt", err_cnt2, e.errc2);
        end
      end
    end
  end

  initial begin
    rst = 1'b1; clear = 1'b0; in_valid = 1'b0;
    a = '0; b = '0; s0 = '0; s1 = '0; co0 = 1'b0; co1 = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    check("reset_in_ready", in_ready, 1);
    check_idle_state("reset");

    // correct sums, without and with carry out
    send(4'd3, 4'd4, 4'd7, 1'b0, 4'd7, 1'b0); drain();
    send(4'd9, 4'd10, 4'd3, 1'b1, 4'd3, 1'b1); drain();
    // impl1 wrong -> flags 110, capture first
    send(4'd5, 4'd6, 4'd11, 1'b0, 4'd10, 1'b0); drain();
    // four more bad tuples; first_* must keep the 5/6 tuple
    send(4'd1, 4'd2, 4'd3, 1'b0, 4'd3, 1'b1); drain();
    send(4'd7, 4'd7, 4'hE, 1'b1, 4'hE, 1'b0); drain();
    send(4'd15, 4'd15, 4'hE, 1'b1, 4'hE, 1'b0); drain();
    send(4'd0, 4'd0, 4'd1, 1'b0, 4'd0, 1'b0); drain();

    do_clear();

    // 8 good tuples back to back; the last is counted 9 edges after the first accept
    for (int i = 0; i < 8; i++)
      send(4'(i), 4'(i + 3), 4'(2 * i + 3), 1'b0, 4'(2 * i + 3), 1'b0);
    @(posedge clk);              // edge N+7: eighth accept
    @(negedge clk) in_valid = 1'b0;
    @(posedge clk); #1;          // N+8
    check("b2b_cnt_n8", check_cnt, 7);
    @(posedge clk); #1;          // N+9
    check("b2b_cnt_n9", check_cnt, 8);
    drain();

    // fail, then probe in_ready (0 with stop-on-error, 1 otherwise)
    send(4'd5, 4'd6, 4'd11, 1'b0, 4'd10, 1'b0); drain();
    send(4'd2, 4'd2, 4'd4, 1'b0, 4'd4, 1'b0); drain();

    // clear with two tuples in flight: both dropped
    send(4'd1, 4'd1, 4'd2, 1'b0, 4'd2, 1'b0, 1'b0);
    send(4'd2, 4'd1, 4'd3, 1'b0, 4'd3, 1'b0, 1'b0);
    do_clear();
    drain();
    check_idle_state("post_clear");

    // rst mid-stream: two in-flight tuples dropped
    send(4'd4, 4'd4, 4'd8, 1'b0, 4'd8, 1'b0, 1'b0);
    send(4'd4, 4'd5, 4'd9, 1'b0, 4'd9, 1'b0, 1'b0);
    @(negedge clk) rst = 1'b1; in_valid = 1'b0;
    model_reset();
    @(negedge clk) rst = 1'b0;
    drain();
    check_idle_state("midrst");

    // rst and clear together behave as a reset
    send(4'd8, 4'd8, 4'd0, 1'b1, 4'd0, 1'b1); drain();
    @(negedge clk) rst = 1'b1; clear = 1'b1;
    model_reset();
    @(negedge clk) rst = 1'b0; clear = 1'b0;
    #1 check_idle_state("rst_clear");
    send(4'd8, 4'd8, 4'd0, 1'b1, 4'd0, 1'b1); drain();

    check("sb_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
